// File: rtl/score_hud_pkg.sv
`default_nettype none
// ============================================================================
// score_hud_pkg
// Shared definitions for the score HUD: converter FSM encoding, digit-cell
// geometry, seven-segment bounds and small combinational helpers.
// Revision: 1.0 - initial release
// ============================================================================
package score_hud_pkg;

   // Converter FSM encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LATCH   = 2'd2
   } state_t;

   // Double-dabble runs one iteration per score bit
   localparam logic [2:0] LAST_ITER = 3'd7;

   // Digit cell geometry (pixels)
   localparam logic [9:0] CELL_W     = 10'd16;
   localparam logic [9:0] CELL_H     = 10'd24;
   localparam logic [9:0] CELL_PITCH = 10'd20;
   localparam logic [9:0] SEG_T      = 10'd4;

   // Segment bounds in cell-local coordinates
   localparam logic [9:0] SEG_L_X1 = SEG_T - 10'd1;            // f/e: cx 0-3
   localparam logic [9:0] SEG_R_X0 = CELL_W - SEG_T;           // b/c: cx 12-15
   localparam logic [9:0] SEG_A_Y1 = SEG_T - 10'd1;            // a:   cy 0-3
   localparam logic [9:0] SEG_G_Y0 = 10'd10;                   // g:   cy 10-13
   localparam logic [9:0] SEG_G_Y1 = SEG_G_Y0 + SEG_T - 10'd1;
   localparam logic [9:0] SEG_D_Y0 = CELL_H - SEG_T;           // d:   cy 20-23

   // Double-dabble correction: add 3 to any BCD nibble of 5 or more
   function automatic logic [3:0] dabble_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Is cell-local pixel (cx, cy) inside a lit segment? Caller guarantees the
   // point already lies inside the cell. seg = {a,b,c,d,e,f,g}.
   function automatic logic seg_lit(input logic [9:0] cx,
                                    input logic [9:0] cy,
                                    input logic [6:0] seg);
      logic left, right, top, mid, bot, upper, lower;
      left  = (cx <= SEG_L_X1);
      right = (cx >= SEG_R_X0);
      top   = (cy <= SEG_A_Y1);
      mid   = (cy >= SEG_G_Y0) && (cy <= SEG_G_Y1);
      bot   = (cy >= SEG_D_Y0);
      upper = (cy <= SEG_G_Y1);
      lower = (cy >= SEG_G_Y0);
      return (seg[6] & top)           |
             (seg[5] & right & upper) |
             (seg[4] & right & lower) |
             (seg[3] & bot)           |
             (seg[2] & left  & lower) |
             (seg[1] & left  & upper) |
             (seg[0] & mid);
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_hud_seg7.sv
`default_nettype none
// ============================================================================
// seg7_decode
// Combinational BCD digit to seven-segment map, output order {a,b,c,d,e,f,g}.
// Non-decimal codes light nothing.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_decode (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Segment pattern lookup
   always_comb begin
      seg = 7'b0000000;
      case (digit)
         4'd0: seg = 7'b1111110;
         4'd1: seg = 7'b0110000;
         4'd2: seg = 7'b1101101;
         4'd3: seg = 7'b1111001;
         4'd4: seg = 7'b0110011;
         4'd5: seg = 7'b1011011;
         4'd6: seg = 7'b1011111;
         4'd7: seg = 7'b1110000;
         4'd8: seg = 7'b1111111;
         4'd9: seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/score_hud.sv
`default_nettype none
// ============================================================================
// score_hud
// Once per frame converts the binary score to three BCD digits (serial
// double-dabble) and draws them as seven-segment glyphs at (X0, Y0) with
// leading-zero blanking. pixel_on is registered one cycle behind hpos/vpos.
// Revision: 1.0 - initial release
// ============================================================================
module score_hud #(
   parameter int X0 = 8,
   parameter int Y0 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  score,
   input  logic        frame_start,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   output logic        pixel_on,
   output logic        busy,
   output logic [11:0] digits
);
   import score_hud_pkg::*;

   localparam logic [9:0] X0_P = 10'(X0);
   localparam logic [9:0] Y0_P = 10'(Y0);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  shreg;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  iter;

   assign busy    = (state != IDLE);
   assign bcd_adj = {dabble_adj(bcd[11:8]), dabble_adj(bcd[7:4]), dabble_adj(bcd[3:0])};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; frame_start is only honoured from IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = CONVERT;
         CONVERT: if (iter == LAST_ITER) state_nxt = LATCH;
         LATCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Conversion datapath: capture, correct-then-shift, and publish in LATCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg  <= 8'd0;
         bcd    <= 12'd0;
         iter   <= 3'd0;
         digits <= 12'd0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  shreg <= score;
                  bcd   <= 12'd0;
                  iter  <= 3'd0;
               end
            end
            CONVERT: begin
               bcd   <= {bcd_adj[10:0], shreg[7]};
               shreg <= {shreg[6:0], 1'b0};
               iter  <= iter + 3'd1;
            end
            LATCH:   digits <= bcd;
            default: ;
         endcase
      end
   end

   // Pixel geometry: row band shared by all cells, guarded against wrap
   logic [9:0] dy;
   logic       in_y;
   logic [2:0] blank;
   logic [2:0] cell_hit;

   assign dy    = vpos - Y0_P;
   assign in_y  = (vpos >= Y0_P) && (dy < CELL_H);
   assign blank = {1'b0,
                   (digits[11:8] == 4'd0) && (digits[7:4] == 4'd0),
                   (digits[11:8] == 4'd0)};

   generate
      for (genvar k = 0; k < 3; k++) begin : g_cell
         localparam logic [9:0] LEFT = X0_P + 10'(k) * CELL_PITCH;
         logic [9:0] cx;
         logic [6:0] seg;
         logic       in_x;

         assign cx   = hpos - LEFT;
         assign in_x = (hpos >= LEFT) && (cx < CELL_W);

         seg7_decode u_dec (
            .digit (digits[11-4*k -: 4]),
            .seg   (seg)
         );

         assign cell_hit[k] = in_x && in_y && !blank[k] && seg_lit(cx, dy, seg);
      end
   endgenerate

   // Registered foreground output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pixel_on <= 1'b0;
      else        pixel_on <= |cell_hit;
   end

endmodule
`default_nettype wire

// File: tb/tb_score_hud.sv
`default_nettype none
// ============================================================================
// tb_score_hud
// Self-checking bench for score_hud: conversion vectors with a scoreboard
// queue, pixel vectors per displayed value, and hand-written corner cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_score_hud;

   localparam int X0 = 8;
   localparam int Y0 = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  score;
   logic        frame_start;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        pixel_on;
   logic        busy;
   logic [11:0] digits;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  score;
      logic [11:0] exp;
   } conv_vec_t;

   typedef struct {
      logic [11:0] shown;
      logic [9:0]  h;
      logic [9:0]  v;
      logic        exp;
   } pix_vec_t;

   logic [11:0] sb_q[$];
   conv_vec_t   cv[$];
   pix_vec_t    pv[$];

   always #20 clk = ~clk;

   score_hud #(.X0(X0), .Y0(Y0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .score       (score),
      .frame_start (frame_start),
      .hpos        (hpos),
      .vpos        (vpos),
      .pixel_on    (pixel_on),
      .busy        (busy),
      .digits      (digits)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic add_cv(input logic [7:0] s, input logic [11:0] e);
      conv_vec_t r;
      r.score = s;
      r.exp   = e;
      cv.push_back(r);
   endtask

   task automatic add_pv(input logic [11:0] sh, input int h, input int v, input logic e);
      pix_vec_t r;
      r.shown = sh;
      r.h     = 10'(h);
      r.v     = 10'(v);
      r.exp   = e;
      pv.push_back(r);
   endtask

   // One full conversion; score is scrambled right after capture.
   task automatic run_conv(input logic [7:0] s, input logic [11:0] e, input string name);
      logic [11:0] prev;
      logic [11:0] want;
      prev        = digits;
      score       = s;
      frame_start = 1'b1;
      sb_q.push_back(e);
      tick();                                   // edge 1
      frame_start = 1'b0;
      score       = ~s;
      check({name, " busy@e1"}, busy, 1);
      repeat (8) tick();                        // edges 2..9
      check({name, " busy@e9"}, busy, 1);
      check({name, " digits held@e9"}, digits, prev);
      tick();                                   // edge 10
      want = sb_q.pop_front();
      check({name, " digits@e10"}, digits, want);
      check({name, " busy@e10"}, busy, 0);
   endtask

   task automatic pix_table(input logic [11:0] shown);
      foreach (pv[i]) begin
         if (pv[i].shown == shown) begin
            hpos = pv[i].h;
            vpos = pv[i].v;
            tick();
            check($sformatf("pix %03h (%0d,%0d)", shown, pv[i].h, pv[i].v), pixel_on, pv[i].exp);
         end
      end
   endtask

   initial begin
      logic seen_busy;

      // Conversion vectors
      add_cv(8'd0,   12'h000);
      add_cv(8'd9,   12'h009);
      add_cv(8'd10,  12'h010);
      add_cv(8'd99,  12'h099);
      add_cv(8'd100, 12'h100);
      add_cv(8'd199, 12'h199);
      add_cv(8'd128, 12'h128);

      // Pixel vectors: value shown, beam position, expected pixel_on
      add_pv(12'h000, 48, 8, 1);   add_pv(12'h000, 8, 8, 0);    add_pv(12'h000, 28, 8, 0);
      add_pv(12'h000, 54, 20, 0);  add_pv(12'h000, 49, 20, 1);  add_pv(12'h000, 54, 14, 0);
      add_pv(12'h000, 63, 31, 1);  add_pv(12'h000, 64, 8, 0);   add_pv(12'h000, 48, 32, 0);
      add_pv(12'h000, 7, 8, 0);    add_pv(12'h000, 48, 7, 0);
      add_pv(12'h255, 10, 9, 1);   add_pv(12'h255, 25, 13, 0);  add_pv(12'h255, 608, 8, 0);
      add_pv(12'h255, 8, 32, 0);   add_pv(12'h255, 21, 13, 1);  add_pv(12'h255, 9, 13, 0);
      add_pv(12'h255, 9, 26, 1);   add_pv(12'h255, 41, 13, 0);  add_pv(12'h255, 29, 13, 1);
      add_pv(12'h255, 61, 26, 1);  add_pv(12'h255, 54, 20, 1);  add_pv(12'h255, 45, 8, 0);
      add_pv(12'h100, 28, 8, 1);   add_pv(12'h100, 34, 20, 0);  add_pv(12'h100, 8, 8, 0);
      add_pv(12'h100, 21, 10, 1);  add_pv(12'h100, 48, 8, 1);
      add_pv(12'h007, 28, 8, 0);   add_pv(12'h007, 48, 8, 1);   add_pv(12'h007, 49, 13, 0);
      add_pv(12'h007, 61, 13, 1);  add_pv(12'h007, 8, 8, 0);

      // Reset state
      rst_n = 1'b0; frame_start = 1'b0; score = 8'd0; hpos = 10'd0; vpos = 10'd0;
      tick(); tick();
      check("reset digits", digits, 12'h000);
      check("reset busy", busy, 0);
      check("reset pixel_on", pixel_on, 0);
      rst_n = 1'b1;
      tick();
      pix_table(12'h000);

      // Maximum score and its glyphs
      run_conv(8'd255, 12'h255, "conv 255");
      pix_table(12'h255);

      // Vector table
      foreach (cv[i]) run_conv(cv[i].score, cv[i].exp, $sformatf("conv %0d", cv[i].score));

      // Score change without frame_start leaves display alone
      run_conv(8'd7, 12'h007, "conv 7");
      pix_table(12'h007);
      score = 8'd8;
      repeat (15) tick();
      check("no frame_start digits", digits, 12'h007);
      check("no frame_start busy", busy, 0);
      run_conv(8'd8, 12'h008, "conv 8");

      // frame_start while busy is ignored, not queued
      score = 8'd42; frame_start = 1'b1;
      sb_q.push_back(12'h042);
      tick();                                   // edge 1
      frame_start = 1'b0;
      tick(); tick();                           // edges 2,3
      score = 8'd99; frame_start = 1'b1;
      tick();                                   // edge 4
      frame_start = 1'b0;
      check("retrigger busy@e4", busy, 1);
      repeat (5) tick();                        // edges 5..9
      check("retrigger busy@e9", busy, 1);
      check("retrigger digits held", digits, 12'h008);
      tick();                                   // edge 10
      check("retrigger digits@e10", digits, sb_q.pop_front());
      check("retrigger busy@e10", busy, 0);
      seen_busy = 1'b0;
      repeat (12) begin
         tick();
         seen_busy = seen_busy | busy;
      end
      check("retrigger single window", seen_busy, 0);
      check("retrigger digits final", digits, 12'h042);

      // Reset in the middle of a conversion
      score = 8'd77; frame_start = 1'b1;
      tick();                                   // edge 1
      frame_start = 1'b0;
      repeat (3) tick();                        // edges 2..4
      #5 rst_n = 1'b0;
      #1;
      check("async reset busy", busy, 0);
      check("async reset digits", digits, 12'h000);
      tick(); tick();
      rst_n = 1'b1;
      repeat (12) tick();
      check("post-reset digits", digits, 12'h000);
      check("post-reset busy", busy, 0);
      pix_table(12'h000);
      run_conv(8'd100, 12'h100, "conv after reset");
      pix_table(12'h100);

      // Full sweep against the decimal model
      for (int v = 0; v < 256; v++) run_conv(8'(v), to_bcd(v), $sformatf("sweep %0d", v));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/score_hud.md
SCORE_HUD -- requirements
Module: score_hud

Interface
REQ-001 Parameter X0, default 8: left pixel column of the score box.
REQ-002 Parameter Y0, default 8: top pixel row of the score box.
REQ-003 clk input 1: 25 MHz pixel clock, the block's only clock.
REQ-004 rst_n input 1: reset, asynchronous assert, active-low.
REQ-005 score input 8: binary score from the scroll/score counter; may change on any cycle.
REQ-006 frame_start input 1: single-cycle pulse once per frame, during vertical blanking.
REQ-007 hpos input 10: current beam column, 0-639.
REQ-008 vpos input 10: current beam row, 0-479.
REQ-009 pixel_on output 1: registered; 1 = draw score foreground at the beam position presented one cycle earlier.
REQ-010 busy output 1: high while a conversion is in progress.
REQ-011 digits output 12: displayed BCD value {hundreds, tens, units}, 4 bits each.

Function
REQ-012 FSM states SHALL be IDLE, CONVERT and LATCH; the reset state is IDLE.
REQ-013 IDLE with frame_start=1: capture score into an 8-bit shift register, clear a 12-bit BCD accumulator, set iteration count 0, go to CONVERT.
REQ-014 CONVERT: on each cycle, first add 3 to every BCD nibble >= 5, then shift {BCD, shift register} left by 1; after the 8th iteration, go to LATCH.
REQ-015 LATCH: copy the accumulator to digits, go to IDLE.
REQ-016 Latency: counting the edge that samples frame_start as edge 1, digits SHALL update on edge 10.
REQ-017 busy SHALL be 1 from after edge 1 through edge 10, otherwise 0.
REQ-018 frame_start while busy=1 SHALL be ignored: no restart and no queuing.
REQ-019 score changes during CONVERT SHALL NOT affect the conversion in progress.
REQ-020 digits SHALL change only in LATCH, so the displayed value is stable for a whole frame.
REQ-021 Digit cell k (0=hundreds, 1=tens, 2=units) SHALL occupy x in [X0+20k, X0+20k+15] and y in [Y0, Y0+23]; cell-local coordinates are (cx, cy).
REQ-022 Segments SHALL be: a = cy 0-3; g = cy 10-13; d = cy 20-23 (each full cell width); f = cx 0-3, cy 0-13; b = cx 12-15, cy 0-13; e = cx 0-3, cy 10-23; c = cx 12-15, cy 10-23.
REQ-023 pixel_on SHALL be 1 iff the beam lies in a lit segment of a non-blanked digit.
REQ-024 Leading zeros SHALL be blanked: hundreds is blanked if 0; tens is blanked if hundreds is 0 and tens is 0; units is never blanked.
REQ-025 Pixels outside all three cells, including the 4-pixel gaps between cells, SHALL give pixel_on=0.
REQ-026 Cell-relative arithmetic SHALL use 10 bits, and out-of-range coordinates SHALL NOT wrap into a cell.

Reset
REQ-027 While rst_n=0: state IDLE; digits, pixel_on, busy, shift register, BCD accumulator and iteration count all 0.
REQ-028 Reset asserted mid-CONVERT SHALL abort the conversion, with digits remaining 0 until the next full conversion.
REQ-029 After reset, the display SHALL show a single "0" in the units cell.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, CELL_W=16, CELL_H=24, CELL_PITCH=20, SEG_T=4 and the segment row/column bounds.
REQ-031 The BCD-to-seven-segment map SHALL be a combinational sub-module seg7_decode (4-bit digit in, 7-bit a-g out), instantiated once per cell.
REQ-032 The converter FSM and pixel logic SHALL reside in score_hud; no other clocks, and no memories.

Verification
REQ-033 Reset release, then sample (X0+40, Y0) -> pixel_on=1 one cycle later; (X0, Y0) -> 0; digits=12'h000.
REQ-034 score=255, frame_start pulse -> busy high edges 1-10; digits=12'h255 from edge 10; (X0+2, Y0+1) -> pixel_on=1.
REQ-035 score=7, then score=8 with no frame_start -> digits stays 12'h007; the next frame_start gives 12'h008.
REQ-036 Second frame_start 3 cycles after the first, with score changed 42->99 -> result 12'h042 only, with a single busy window.
REQ-037 rst_n low at edge 5 of conversion -> busy=0 and digits=0 asynchronously; after release, a frame_start with score=100 gives 12'h100.
REQ-038 Sweep score 0-255 -> digits match the decimal value each time; (X0+17, Y0+5), (X0+600, Y0) and (X0, Y0+24) -> pixel_on=0.
